// File: rtl/sync_delay_ctrl.sv
// Measures the hsync line period, locks on a stable period, then resets, settles, frame-aligns, fills and supervises the delay FIFO.
// All outputs are registered and follow the state entered at the previous edge; fifo_full/fifo_empty are acted on only while running.
module sync_delay_ctrl #(
    parameter int MAX_WIDTH     = 4096,
    parameter int MIN_WIDTH     = 64,
    parameter int DELAY_ROWS    = 15,
    parameter int DELAY_COLS    = 15,
    parameter int FIFO_DEPTH    = 32768,
    parameter int LOCK_LINES    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int LW            = $clog2(MAX_WIDTH + 1),
    parameter int DW            = $clog2(DELAY_ROWS * MAX_WIDTH + DELAY_COLS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    output logic          fifo_rst,
    output logic          fifo_wr_en,
    output logic          fifo_rd_en,
    output logic          locked,
    output logic [LW-1:0] line_len,
    output logic [DW-1:0] delay_depth,
    output logic [1:0]    err_code,
    output logic [7:0]    err_count
);

    localparam int MW = $clog2(LOCK_LINES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [LW-1:0] PER_MIN     = LW'(MIN_WIDTH);
    localparam logic [LW-1:0] PER_MAX     = LW'(MAX_WIDTH);
    localparam logic [LW-1:0] PER_SAT     = LW'(MAX_WIDTH + 1);
    localparam logic [MW-1:0] MATCH_LOCK  = MW'(LOCK_LINES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ERR_LINE  = 2'd1;
    localparam logic [1:0] ERR_DEPTH = 2'd2;
    localparam logic [1:0] ERR_FIFO  = 2'd3;

    typedef enum logic [2:0] {
        S_MEASURE,
        S_SETTLE,
        S_ARM,
        S_FILL,
        S_RUN,
        S_ERROR
    } state_t;

    state_t        state;
    logic          hsync_q;
    logic          vsync_q;
    logic          hs_rise;
    logic          vs_rise;
    logic          have_start;
    logic          period_vld;
    logic          period_ok;
    logic [LW-1:0] per_cnt;
    logic [LW-1:0] candidate;
    logic [MW-1:0] match;
    logic [1:0]    miss;
    logic [SW-1:0] settle_cnt;
    logic [DW-1:0] fill_cnt;
    logic [DW-1:0] depth_calc;
    logic          depth_over;

    assign hs_rise    = hsync_in & ~hsync_q;
    assign vs_rise    = vsync_in & ~vsync_q;
    // A period exists only once a previous hs_rise has started the counter.
    assign period_vld = hs_rise & have_start;
    assign period_ok  = (per_cnt >= PER_MIN) && (per_cnt <= PER_MAX);
    assign depth_calc = DW'(DELAY_ROWS) * DW'(per_cnt) + DW'(DELAY_COLS);
    assign depth_over = 64'(depth_calc) > 64'(FIFO_DEPTH - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_MEASURE;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            have_start  <= 1'b0;
            per_cnt     <= '0;
            candidate   <= '0;
            match       <= '0;
            miss        <= '0;
            settle_cnt  <= '0;
            fill_cnt    <= '0;
            fifo_rst    <= 1'b1;
            fifo_wr_en  <= 1'b0;
            fifo_rd_en  <= 1'b0;
            locked      <= 1'b0;
            line_len    <= '0;
            delay_depth <= '0;
            err_code    <= '0;
            err_count   <= '0;
        end else begin
            hsync_q <= hsync_in;
            vsync_q <= vsync_in;

            if (hs_rise) begin
                per_cnt    <= LW'(1);
                have_start <= 1'b1;
            end else if (per_cnt != PER_SAT) begin
                per_cnt <= per_cnt + 1'b1;
            end

            case (state)
                S_MEASURE: begin
                    if (period_vld) begin
                        if (period_ok && per_cnt == candidate) begin
                            match <= match + 1'b1;
                            if (match + 1'b1 == MATCH_LOCK) begin
                                line_len    <= per_cnt;
                                delay_depth <= depth_calc;
                                if (depth_over) begin
                                    state     <= S_ERROR;
                                    err_code  <= ERR_DEPTH;
                                    err_count <= sat_inc(err_count);
                                end else begin
                                    state      <= S_SETTLE;
                                    settle_cnt <= '0;
                                    fifo_rst   <= 1'b0;
                                end
                            end
                        end else begin
                            candidate <= period_ok ? per_cnt : '0;
                            match     <= '0;
                        end
                    end
                end

                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_ARM;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                S_ARM: begin
                    if (vs_rise) begin
                        state      <= S_FILL;
                        fifo_wr_en <= 1'b1;
                        fill_cnt   <= DW'(1);
                    end
                end

                // fill_cnt numbers the current write cycle; reads start on write delay_depth+1.
                S_FILL: begin
                    if (fill_cnt == delay_depth) begin
                        state      <= S_RUN;
                        fifo_rd_en <= 1'b1;
                        locked     <= 1'b1;
                        miss       <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (fifo_full || fifo_empty) begin
                        state      <= S_ERROR;
                        err_code   <= ERR_FIFO;
                        err_count  <= sat_inc(err_count);
                        fifo_rst   <= 1'b1;
                        fifo_wr_en <= 1'b0;
                        fifo_rd_en <= 1'b0;
                        locked     <= 1'b0;
                    end else if (period_vld) begin
                        if (period_ok && per_cnt == line_len) begin
                            miss <= '0;
                        end else if (miss == 2'd1) begin
                            state      <= S_ERROR;
                            err_code   <= ERR_LINE;
                            err_count  <= sat_inc(err_count);
                            fifo_rst   <= 1'b1;
                            fifo_wr_en <= 1'b0;
                            fifo_rd_en <= 1'b0;
                            locked     <= 1'b0;
                        end else begin
                            miss <= miss + 1'b1;
                        end
                    end
                end

                S_ERROR: begin
                    state      <= S_MEASURE;
                    candidate  <= '0;
                    match      <= '0;
                    miss       <= '0;
                    have_start <= 1'b0;
                end

                default: begin
                    state <= S_MEASURE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_delay_ctrl.sv
// Bench for sync_delay_ctrl: randomized line periods against expectations derived from the period/depth rules.
module tb_sync_delay_ctrl;

    localparam int MAX_W  = 256;
    localparam int MIN_W  = 16;
    localparam int ROWS   = 3;
    localparam int COLS   = 7;
    localparam int FDEPTH = 512;
    localparam int LOCKN  = 4;
    localparam int SETTLE = 16;
    localparam int LW     = $clog2(MAX_W + 1);
    localparam int DW     = $clog2(ROWS * MAX_W + COLS + 1);
    localparam int BOUND  = 8000;
    localparam int W_RST  = 0;
    localparam int W_WR   = 1;
    localparam int W_RD   = 2;
    localparam int W_LOCK = 3;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          hsync_in   = 1'b0;
    logic          vsync_in   = 1'b0;
    logic          fifo_full  = 1'b0;
    logic          fifo_empty = 1'b0;
    logic          fifo_rst;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic          locked;
    logic [LW-1:0] line_len;
    logic [DW-1:0] delay_depth;
    logic [1:0]    err_code;
    logic [7:0]    err_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_period = 0;
    int hs_phase = 0;
    int hs_count = 0;
    int line_no = 0;
    int vs_every = 4;
    int vs_cyc = -100;
    bit alt = 1'b0;

    sync_delay_ctrl #(
        .MAX_WIDTH    (MAX_W),
        .MIN_WIDTH    (MIN_W),
        .DELAY_ROWS   (ROWS),
        .DELAY_COLS   (COLS),
        .FIFO_DEPTH   (FDEPTH),
        .LOCK_LINES   (LOCKN),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_rst   (fifo_rst),
        .fifo_wr_en (fifo_wr_en),
        .fifo_rd_en (fifo_rd_en),
        .locked     (locked),
        .line_len   (line_len),
        .delay_depth(delay_depth),
        .err_code   (err_code),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sync source: one-cycle hsync pulses every hs_period clocks, vsync with every vs_every-th hsync.
    initial begin : sync_gen
        int eff;
        forever begin
            @(negedge clk);
            eff = hs_period + ((alt && (hs_count % 2 == 1)) ? 1 : 0);
            if (hs_period == 0) begin
                hsync_in = 1'b0;
                vsync_in = 1'b0;
            end else if (hs_phase >= eff - 1) begin
                hs_phase = 0;
                hsync_in = 1'b1;
                hs_count++;
                line_no++;
                if (line_no >= vs_every) begin
                    line_no  = 0;
                    vsync_in = 1'b1;
                    vs_cyc   = cyc;
                end else begin
                    vsync_in = 1'b0;
                end
            end else begin
                hs_phase++;
                hsync_in = 1'b0;
                vsync_in = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_sig(input int w);
        case (w)
            W_RST:   return fifo_rst;
            W_WR:    return fifo_wr_en;
            W_RD:    return fifo_rd_en;
            default: return locked;
        endcase
    endfunction

    task automatic wait_until(input int w, input logic v, input int limit, input string tag);
        int n = 0;
        while (get_sig(w) !== v && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(get_sig(w)), 32'(v));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_fifo_rst"}, 32'(fifo_rst), 1);
        check({tag, "_wr_en"}, 32'(fifo_wr_en), 0);
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_line_len"}, 32'(line_len), 0);
        check({tag, "_delay_depth"}, 32'(delay_depth), 0);
        check({tag, "_err_code"}, 32'(err_code), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
    endtask

    task automatic start_hs(input int p, input bit a);
        hs_phase  = 0;
        hs_count  = 0;
        line_no   = 0;
        alt       = a;
        hs_period = p;
    endtask

    task automatic restart(input int p, input bit a);
        rst       = 1'b1;
        hs_period = 0;
        tick();
        tick();
        rst = 1'b0;
        start_hs(p, a);
    endtask

    initial begin : main
        int  p, p2, p3, k, c0, w0, base, n;
        bit  ok;

        repeat (3) tick();
        check_reset("init");

        // Lock at a random legal period and walk the whole start-up sequence.
        p = $urandom_range(MIN_W + 8, 168);
        restart(p, 1'b0);
        wait_until(W_RST, 1'b0, BOUND, "lock_fifo_rst_fall");
        check("lock_hs_events", hs_count, LOCKN + 1);
        check("lock_line_len", 32'(line_len), p);
        check("lock_depth", 32'(delay_depth), ROWS * p + COLS);
        check("lock_locked_low", 32'(locked), 0);
        c0 = cyc;
        n  = 0;
        while (fifo_wr_en !== 1'b1 && n < BOUND) begin
            fifo_full = 1'($urandom % 2);
            tick();
            n++;
        end
        fifo_full = 1'b0;
        check("first_wr", 32'(fifo_wr_en), 1);
        check("settle_min_len", 32'((cyc - c0) >= SETTLE + 1), 1);
        check("wr_after_vs", cyc, vs_cyc + 1);
        w0 = cyc;
        ok = 1'b1;
        n  = 0;
        while (fifo_rd_en !== 1'b1 && n < FDEPTH + 10) begin
            ok = ok & (fifo_wr_en === 1'b1) & (locked === 1'b0) & (fifo_rst === 1'b0);
            fifo_empty = 1'($urandom % 2);
            tick();
            n++;
        end
        fifo_empty = 1'b0;
        check("first_rd", 32'(fifo_rd_en), 1);
        check("fill_length", cyc - w0, ROWS * p + COLS);
        check("locked_with_rd", 32'(locked), 1);
        check("fill_wr_held", 32'(ok), 1);
        ok = 1'b1;
        repeat (3 * vs_every * p) begin
            ok = ok & (locked === 1'b1) & (fifo_wr_en === 1'b1) & (fifo_rd_en === 1'b1)
                    & (fifo_rst === 1'b0) & (err_count === 8'd0);
            tick();
        end
        check("run_3_frames_stable", 32'(ok), 1);

        // One-cycle FIFO flag in RUN.
        repeat ($urandom_range(1, 200)) tick();
        if ($urandom % 2 == 0) fifo_full = 1'b1;
        else fifo_empty = 1'b1;
        tick();
        fifo_full  = 1'b0;
        fifo_empty = 1'b0;
        check("fault_err_code", 32'(err_code), 3);
        check("fault_err_count", 32'(err_count), 1);
        check("fault_locked", 32'(locked), 0);
        check("fault_fifo_rst", 32'(fifo_rst), 1);
        check("fault_wr_en", 32'(fifo_wr_en), 0);
        check("fault_rd_en", 32'(fifo_rd_en), 0);
        tick();
        check("fault_fifo_rst_hold", 32'(fifo_rst), 1);
        wait_until(W_LOCK, 1'b1, BOUND, "fault_relock");
        check("fault_code_held", 32'(err_code), 3);
        check("fault_relock_len", 32'(line_len), p);

        // Line period change in RUN: second mismatching line drops lock.
        n = 0;
        while (hsync_in !== 1'b1 && n < MAX_W + 4) begin
            tick();
            n++;
        end
        p2 = $urandom_range(MIN_W + 8, 168);
        if (p2 == p) p2 = p - 1;
        base      = hs_count;
        hs_period = p2;
        n         = 0;
        while (int'(err_count) != 2 && n < BOUND) begin
            tick();
            n++;
        end
        check("line_err_count", 32'(err_count), 2);
        check("line_err_code", 32'(err_code), 1);
        check("line_err_hs_events", hs_count - base, 2);
        check("line_err_locked", 32'(locked), 0);
        wait_until(W_LOCK, 1'b1, BOUND, "line_relock");
        check("line_relock_len", 32'(line_len), p2);
        check("line_relock_depth", 32'(delay_depth), ROWS * p2 + COLS);

        // Reset from RUN, then again midway through FILL.
        rst = 1'b1;
        tick();
        check_reset("run_rst");
        rst = 1'b0;
        wait_until(W_WR, 1'b1, BOUND, "rst_fill_start");
        k = $urandom_range(1, ROWS * p2 + COLS - 1);
        repeat (k) tick();
        check("fill_mid_wr", 32'(fifo_wr_en), 1);
        check("fill_mid_rd", 32'(fifo_rd_en), 0);
        rst = 1'b1;
        tick();
        check_reset("fill_rst");
        rst = 1'b0;
        wait_until(W_LOCK, 1'b1, BOUND, "fill_rst_relock");
        check("fill_rst_relock_len", 32'(line_len), p2);
        check("fill_rst_relock_errs", 32'(err_count), 0);

        // Too deep for the FIFO: DEPTH error on every lock attempt, never a write.
        p3 = $urandom_range(169, MAX_W);
        restart(p3, 1'b0);
        ok = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            base = hs_count;
            n    = 0;
            while (int'(err_count) != i && n < BOUND) begin
                ok = ok & (fifo_wr_en === 1'b0);
                tick();
                n++;
            end
            check("depth_err_count", 32'(err_count), i);
            check("depth_err_code", 32'(err_code), 2);
            check("depth_hs_per_try", hs_count - base, LOCKN + 1);
            check("depth_fifo_rst", 32'(fifo_rst), 1);
        end
        check("depth_value", 32'(delay_depth), ROWS * p3 + COLS);
        check("depth_no_wr", 32'(ok), 1);

        // Largest period whose depth still fits (depth == FIFO_DEPTH-1).
        restart(168, 1'b0);
        wait_until(W_RST, 1'b0, BOUND, "edge_depth_lock");
        check("edge_depth_value", 32'(delay_depth), FDEPTH - 1);
        wait_until(W_WR, 1'b1, BOUND, "edge_depth_wr");
        check("edge_depth_no_err", 32'(err_count), 0);

        // Unstable or illegal periods must never leave MEASURE.
        p = $urandom_range(MIN_W + 8, 160);
        restart(p, 1'b1);
        ok = 1'b1;
        repeat (20 * (p + 1)) begin
            ok = ok & (fifo_rst === 1'b1);
            tick();
        end
        check("alt_period_no_lock", 32'(ok), 1);
        check("alt_period_line_len", 32'(line_len), 0);

        p = $urandom_range(4, MIN_W - 1);
        restart(p, 1'b0);
        ok = 1'b1;
        repeat (10 * p) begin
            ok = ok & (fifo_rst === 1'b1);
            tick();
        end
        check("short_period_no_lock", 32'(ok), 1);

        p = $urandom_range(MAX_W + 1, MAX_W + 40);
        restart(p, 1'b0);
        ok = 1'b1;
        repeat (8 * p) begin
            ok = ok & (fifo_rst === 1'b1);
            tick();
        end
        check("long_period_no_lock", 32'(ok), 1);
        check("long_period_no_err", 32'(err_count), 0);

        // Shortest legal period locks and runs.
        restart(MIN_W, 1'b0);
        wait_until(W_LOCK, 1'b1, BOUND, "min_period_lock");
        check("min_period_len", 32'(line_len), MIN_W);
        check("min_period_depth", 32'(delay_depth), ROWS * MIN_W + COLS);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
